// File: rtl/xillybus_apfifo_bridge.sv
// Xillybus 128-bit stream pair to HLS ap_fifo bridge: FIFO A feeds the accelerator
// (FWFT read side); FIFO B returns results to the host with EOF sequencing and flush on close.
module xillybus_apfifo_bridge #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 4
) (
   input  logic              bus_clk,
   input  logic              reset,
   // host -> FPGA stream
   input  logic              user_w_write_128_wren,
   input  logic [DATA_W-1:0] user_w_write_128_data,
   output logic              user_w_write_128_full,
   input  logic              user_w_write_128_open,
   // FPGA -> host stream
   input  logic              user_r_read_128_rden,
   output logic [DATA_W-1:0] user_r_read_128_data,
   output logic              user_r_read_128_empty,
   output logic              user_r_read_128_eof,
   input  logic              user_r_read_128_open,
   // accelerator ap_fifo read port
   output logic [DATA_W-1:0] in_dout,
   output logic              in_empty_n,
   input  logic              in_read,
   output logic              in_closed,
   // accelerator ap_fifo write port
   input  logic [DATA_W-1:0] out_din,
   output logic              out_full_n,
   input  logic              out_write,
   input  logic              out_last,
   // status
   output logic              overflow
);

   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   typedef enum logic [1:0] {
      RD_CLOSED = 2'd0,
      RD_STREAM = 2'd1,
      RD_DRAIN  = 2'd2,
      RD_EOF    = 2'd3
   } rd_state_t;

   // ------------------------------------------------------------------
   // FIFO A: host -> accelerator
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] mem_a [DEPTH];
   logic [ADDR_W-1:0] wptr_a, rptr_a;
   logic [ADDR_W:0]   cnt_a;
   logic              full_a, empty_a, push_a, pop_a, drop_a;

   assign full_a  = (cnt_a == FULL_CNT);
   assign empty_a = (cnt_a == '0);
   assign pop_a   = in_read && !empty_a;
   // A pop frees the slot this cycle, so a push at full is still taken.
   assign push_a  = user_w_write_128_wren && (!full_a || pop_a);
   assign drop_a  = user_w_write_128_wren && !push_a;

   // NOTE: storage arrays carry no reset; only pointers and counts define
   // which entries are valid, and leaving the RAM unreset lets it map to block/distributed RAM.
   always_ff @(posedge bus_clk) begin
      if (push_a) mem_a[wptr_a] <= user_w_write_128_data;
   end

   // NOTE: every clocked state update uses non-blocking assignment so all
   // registers see pre-edge values regardless of statement order.
   always_ff @(posedge bus_clk) begin
      if (reset) begin
         wptr_a <= '0;
         rptr_a <= '0;
         cnt_a  <= '0;
      end else begin
         if (push_a) wptr_a <= wptr_a + PTR_ONE;
         if (pop_a)  rptr_a <= rptr_a + PTR_ONE;
         case ({push_a, pop_a})
            2'b10:   cnt_a <= cnt_a + CNT_ONE;
            2'b01:   cnt_a <= cnt_a - CNT_ONE;
            default: cnt_a <= cnt_a;
         endcase
      end
   end

   assign user_w_write_128_full = full_a;
   assign in_dout               = mem_a[rptr_a];
   assign in_empty_n            = !empty_a;
   assign in_closed             = !user_w_write_128_open && empty_a;

   // ------------------------------------------------------------------
   // FIFO B: accelerator -> host, controlled by the read-channel FSM
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] mem_b [DEPTH];
   logic [ADDR_W-1:0] wptr_b, rptr_b;
   logic [ADDR_W:0]   cnt_b;
   logic              full_b, empty_b;
   logic              push_b, pop_b, drop_b, flush_b;
   logic [DATA_W-1:0] rd_data_q;
   logic              eof_q;
   rd_state_t         state, state_nxt;

   assign full_b  = (cnt_b == FULL_CNT);
   assign empty_b = (cnt_b == '0);

   // NOTE: combinational blocks assign every output a default first, so no
   // path through the case/if tree can leave a signal unassigned (no latch).
   always_comb begin
      state_nxt  = state;
      out_full_n = 1'b0;
      push_b     = 1'b0;
      pop_b      = 1'b0;
      drop_b     = 1'b0;
      flush_b    = 1'b0;

      case (state)
         RD_CLOSED: begin
            out_full_n = 1'b1;
            if (user_r_read_128_open) state_nxt = RD_STREAM;
         end
         RD_STREAM: begin
            out_full_n = !full_b;
            push_b     = out_write && !full_b;
            drop_b     = out_write && full_b;
            pop_b      = user_r_read_128_rden && !empty_b;
            if (push_b && out_last) state_nxt = RD_DRAIN;
         end
         RD_DRAIN: begin
            pop_b = user_r_read_128_rden && !empty_b;
            if (empty_b) state_nxt = RD_EOF;
         end
         RD_EOF: begin
            state_nxt = RD_EOF;
         end
         default: begin
            state_nxt = RD_CLOSED;
         end
      endcase

      // Closing the read file overrides everything on this edge.
      if (!user_r_read_128_open) begin
         state_nxt = RD_CLOSED;
         flush_b   = 1'b1;
         push_b    = 1'b0;
         pop_b     = 1'b0;
         drop_b    = 1'b0;
      end
   end

   always_ff @(posedge bus_clk) begin
      if (push_b) mem_b[wptr_b] <= out_din;
   end

   always_ff @(posedge bus_clk) begin
      if (reset) begin
         state     <= RD_CLOSED;
         wptr_b    <= '0;
         rptr_b    <= '0;
         cnt_b     <= '0;
         rd_data_q <= '0;
         eof_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         eof_q <= (state_nxt == RD_EOF);
         if (flush_b) begin
            wptr_b <= '0;
            rptr_b <= '0;
            cnt_b  <= '0;
         end else begin
            if (push_b) wptr_b <= wptr_b + PTR_ONE;
            if (pop_b) begin
               rptr_b    <= rptr_b + PTR_ONE;
               rd_data_q <= mem_b[rptr_b];
            end
            case ({push_b, pop_b})
               2'b10:   cnt_b <= cnt_b + CNT_ONE;
               2'b01:   cnt_b <= cnt_b - CNT_ONE;
               default: cnt_b <= cnt_b;
            endcase
         end
      end
   end

   assign user_r_read_128_data  = rd_data_q;
   assign user_r_read_128_empty = empty_b;
   assign user_r_read_128_eof   = eof_q;

   // ------------------------------------------------------------------
   // Sticky overflow from either FIFO
   // ------------------------------------------------------------------
   always_ff @(posedge bus_clk) begin
      if (reset)                 overflow <= 1'b0;
      else if (drop_a || drop_b) overflow <= 1'b1;
   end

endmodule

// File: tb/tb_xillybus_apfifo_bridge.sv
// Self-checking bench for xillybus_apfifo_bridge: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_xillybus_apfifo_bridge;

   logic         bus_clk;
   logic         reset;
   logic         w_wren, w_full, w_open;
   logic [127:0] w_data;
   logic         r_rden, r_empty, r_eof, r_open;
   logic [127:0] r_data;
   logic [127:0] in_dout;
   logic         in_empty_n, in_read, in_closed;
   logic [127:0] out_din;
   logic         out_full_n, out_write, out_last;
   logic         overflow;

   xillybus_apfifo_bridge #(.DATA_W(128), .ADDR_W(4)) dut (
      .bus_clk               (bus_clk),
      .reset                 (reset),
      .user_w_write_128_wren (w_wren),
      .user_w_write_128_data (w_data),
      .user_w_write_128_full (w_full),
      .user_w_write_128_open (w_open),
      .user_r_read_128_rden  (r_rden),
      .user_r_read_128_data  (r_data),
      .user_r_read_128_empty (r_empty),
      .user_r_read_128_eof   (r_eof),
      .user_r_read_128_open  (r_open),
      .in_dout               (in_dout),
      .in_empty_n            (in_empty_n),
      .in_read               (in_read),
      .in_closed             (in_closed),
      .out_din               (out_din),
      .out_full_n            (out_full_n),
      .out_write             (out_write),
      .out_last              (out_last),
      .overflow              (overflow)
   );

   initial bus_clk = 1'b0;
   always #5 bus_clk = ~bus_clk;

   int n_checks = 0;
   int n_err    = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   typedef enum int {M_CLOSED, M_STREAM, M_DRAIN, M_EOF} m_state_t;
   logic [127:0] qa[$];
   logic [127:0] qb[$];
   m_state_t     ms     = M_CLOSED;
   logic [127:0] m_data = '0;
   bit           m_ovf  = 1'b0;
   bit           pa, wa, pb, wb;
   int           nb;

   always @(posedge bus_clk) begin
      if (reset) begin
         qa.delete();
         qb.delete();
         ms     = M_CLOSED;
         m_data = '0;
         m_ovf  = 1'b0;
      end else begin
         pa = in_read && qa.size() > 0;
         wa = w_wren && (qa.size() < 16 || pa);
         if (w_wren && !wa) m_ovf = 1'b1;
         if (pa) void'(qa.pop_front());
         if (wa) qa.push_back(w_data);

         if (!r_open) begin
            qb.delete();
            ms = M_CLOSED;
         end else begin
            case (ms)
               M_CLOSED: ms = M_STREAM;
               M_STREAM, M_DRAIN: begin
                  nb = qb.size();
                  pb = r_rden && nb > 0;
                  wb = (ms == M_STREAM) && out_write && nb < 16;
                  if (ms == M_STREAM && out_write && nb == 16) m_ovf = 1'b1;
                  if (pb) m_data = qb.pop_front();
                  if (wb) qb.push_back(out_din);
                  if (wb && out_last)              ms = M_DRAIN;
                  else if (ms == M_DRAIN && nb == 0) ms = M_EOF;
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge bus_clk) begin
      if (cmp_en) begin
         check("w_full",     w_full,     qa.size() == 16);
         check("in_empty_n", in_empty_n, qa.size() > 0);
         if (qa.size() > 0) check("in_dout", in_dout, qa[0]);
         check("in_closed",  in_closed,  !w_open && qa.size() == 0);
         check("r_empty",    r_empty,    qb.size() == 0);
         check("r_data",     r_data,     m_data);
         check("r_eof",      r_eof,      ms == M_EOF);
         check("out_full_n", out_full_n, ms == M_CLOSED || (ms == M_STREAM && qb.size() < 16));
         check("overflow",   overflow,   m_ovf);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge bus_clk);
      #1;
   endtask

   task automatic idle();
      w_wren    = 1'b0;
      in_read   = 1'b0;
      out_write = 1'b0;
      out_last  = 1'b0;
      r_rden    = 1'b0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check_reset_values(input logic wopen_now);
      check("rst w_full",     w_full,     1'b0);
      check("rst r_empty",    r_empty,    1'b1);
      check("rst in_empty_n", in_empty_n, 1'b0);
      check("rst out_full_n", out_full_n, 1'b1);
      check("rst r_eof",      r_eof,      1'b0);
      check("rst overflow",   overflow,   1'b0);
      check("rst r_data",     r_data,     128'h0);
      check("rst in_closed",  in_closed,  !wopen_now);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      w_open  = 1'b0;
      r_open  = 1'b0;
      w_data  = '0;
      out_din = '0;
      idle();
      tick();
      tick();
      check_reset_values(1'b0);
      reset  = 1'b0;
      cmp_en = 1'b1;

      // 1: five words through FIFO A, popped one per cycle
      w_open = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         w_wren = 1'b1;
         w_data = 128'(i);
         tick();
      end
      w_wren = 1'b0;
      check("t1 full", w_full, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         check("t1 in_dout", in_dout, 128'(i));
         in_read = 1'b1;
         tick();
      end
      in_read = 1'b0;
      check("t1 empty_n", in_empty_n, 1'b0);

      // 2: fill FIFO A, overflow on word 17, pop+push at full
      for (int i = 1; i <= 17; i++) begin
         w_wren = 1'b1;
         w_data = 128'(32'h100 + i);
         tick();
         if (i == 16) check("t2 full16", w_full, 1'b1);
      end
      w_wren = 1'b0;
      check("t2 overflow", overflow, 1'b1);
      check("t2 head", in_dout, 128'h101);
      in_read = 1'b1;
      w_wren  = 1'b1;
      w_data  = 128'h200;
      tick();
      w_wren = 1'b0;
      check("t2 full kept", w_full, 1'b1);
      for (int i = 2; i <= 16; i++) begin
         check("t2 pop", in_dout, 128'(32'h100 + i));
         tick();
      end
      check("t2 last", in_dout, 128'h200);
      tick();
      in_read = 1'b0;
      check("t2 drained", in_empty_n, 1'b0);

      // clear sticky overflow before exercising FIFO B
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t2 ovf cleared", overflow, 1'b0);

      // 3: A, B, C with last on C, then drain to EOF
      r_open = 1'b1;
      tick();
      check("t3 full_n open", out_full_n, 1'b1);
      out_write = 1'b1;
      out_din   = 128'hA;
      tick();
      check("t3 empty after A", r_empty, 1'b0);
      out_din = 128'hB;
      tick();
      out_din  = 128'hC;
      out_last = 1'b1;
      tick();
      out_write = 1'b0;
      out_last  = 1'b0;
      check("t3 full_n drain", out_full_n, 1'b0);
      r_rden = 1'b1; tick(); r_rden = 1'b0;
      check("t3 data A", r_data, 128'hA);
      r_rden = 1'b1; tick(); r_rden = 1'b0;
      check("t3 data B", r_data, 128'hB);
      r_rden = 1'b1; tick(); r_rden = 1'b0;
      check("t3 data C", r_data, 128'hC);
      check("t3 empty", r_empty, 1'b1);
      tick();
      check("t3 eof", r_eof, 1'b1);
      check("t3 eof empty", r_empty, 1'b1);
      check("t3 eof full_n", out_full_n, 1'b0);

      // 4: close from EOF, reopen, push D
      r_open = 1'b0;
      tick();
      check("t4 eof cleared", r_eof, 1'b0);
      check("t4 closed full_n", out_full_n, 1'b1);
      r_open = 1'b1;
      tick();
      out_write = 1'b1;
      out_din   = 128'hD;
      tick();
      out_write = 1'b0;
      r_rden = 1'b1; tick(); r_rden = 1'b0;
      check("t4 data D", r_data, 128'hD);
      check("t4 no stale", r_empty, 1'b1);

      // 5: close with 7 words queued while pushing and reading
      for (int i = 0; i < 7; i++) begin
         out_write = 1'b1;
         out_din   = 128'(32'h500 + i);
         tick();
      end
      r_open    = 1'b0;
      out_din   = 128'h5FF;
      r_rden    = 1'b1;
      tick();
      idle();
      check("t5 empty", r_empty, 1'b1);
      check("t5 data held", r_data, 128'hD);
      check("t5 no overflow", overflow, 1'b0);

      // 6: in_closed tracks write-file state and FIFO A occupancy
      for (int i = 0; i < 2; i++) begin
         w_wren = 1'b1;
         w_data = 128'(32'h600 + i);
         tick();
      end
      w_wren = 1'b0;
      w_open = 1'b0;
      #1;
      check("t6 closed busy", in_closed, 1'b0);
      in_read = 1'b1;
      tick();
      tick();
      in_read = 1'b0;
      check("t6 closed drained", in_closed, 1'b1);
      w_open = 1'b1;
      #1;
      check("t6 reopened", in_closed, 1'b0);

      // randomized traffic
      r_open = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         w_wren    = $urandom_range(0, 1);
         w_data    = rnd128();
         in_read   = ($urandom_range(0, 2) == 0);
         out_write = $urandom_range(0, 1);
         out_din   = rnd128();
         out_last  = ($urandom_range(0, 40) == 0);
         r_rden    = ($urandom_range(0, 2) != 0);
         if (r_open) r_open = ($urandom_range(0, 150) != 0);
         else        r_open = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 100) == 0) w_open = !w_open;
         tick();
      end

      // reset mid-stream
      w_open = 1'b1;
      r_open = 1'b1;
      w_wren = 1'b1;
      out_write = 1'b1;
      tick();
      reset = 1'b1;
      idle();
      tick();
      check_reset_values(1'b1);
      reset = 1'b0;
      tick();

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
